energy_controller: RTL and testbench

//  Owns energy state feeding the HUD energy bar: EnergyDone (thermometer of filled cells), EnergyProgress (partial fill).

---
 rtl/energy_pkg.sv | 28 ++
 rtl/frame_tick_detect.sv | 26 ++
 rtl/energy_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_energy_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/energy_pkg.sv
// Shared types and default sizing for the HUD energy controller.
// Optional passive regeneration is enabled by defining ENERGY_REGEN_EN.
package energy_pkg;

    localparam int         DEF_NUM_CELLS         = 5;
    localparam logic [3:0] DEF_PROG_MAX          = 4'd15;
    localparam int         DEF_CELL_FLASH_FRAMES = 8;
    localparam int         DEF_REGEN_FRAMES      = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SPEND = 2'd2
    } energy_state_t;

    // Width needed for a down/up counter that must hold the value max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Turns the FRAME_CLK level, sampled as data on CLK, into a one-cycle tick
// on each rising edge.
module frame_tick_detect (
    input  logic CLK,
    input  logic RESET_H,
    input  logic FRAME_CLK,
    output logic FrameTick
);

    logic r_cur;
    logic r_prev;

    // Two-stage sample of the frame strobe: current and previous level.
    always_ff @(posedge CLK) begin
        if (RESET_H) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= FRAME_CLK;
            r_prev <= r_cur;
        end
    end

    assign FrameTick = r_cur & ~r_prev;

endmodule

// File: rtl/energy_controller.sv
// Energy bar state owner: gain (valid/ready), spend (req/ack/nack), unit-by-unit
// fill with carry into cells, and cell-complete flash. ENERGY_REGEN_EN adds regen.
module energy_controller
    import energy_pkg::*;
#(
    parameter int         NUM_CELLS         = DEF_NUM_CELLS,
    parameter logic [3:0] PROG_MAX          = DEF_PROG_MAX,
    parameter int         CELL_FLASH_FRAMES = DEF_CELL_FLASH_FRAMES
`ifdef ENERGY_REGEN_EN
    ,
    parameter int         REGEN_FRAMES      = DEF_REGEN_FRAMES
`endif
) (
    input  logic                 CLK,
    input  logic                 RESET_H,
    input  logic                 FRAME_CLK,
    input  logic                 GainValid,
    input  logic [3:0]           GainAmt,
    output logic                 GainReady,
    input  logic                 SpendReq,
    output logic                 SpendAck,
    output logic                 SpendNack,
    output logic [NUM_CELLS-1:0] EnergyDone,
    output logic [3:0]           EnergyProgress,
    output logic                 EnergyFull,
    output logic                 CellFlash
);

    localparam int                 FLASH_W    = cnt_width(CELL_FLASH_FRAMES);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(CELL_FLASH_FRAMES);
    localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);

    energy_state_t        r_state;
    energy_state_t        w_state_nxt;
    logic [3:0]           r_pending;
    logic [3:0]           w_pending_nxt;
    logic [NUM_CELLS-1:0] r_done;
    logic [NUM_CELLS-1:0] w_done_nxt;
    logic [3:0]           r_prog;
    logic [3:0]           w_prog_nxt;
    logic                 r_full;
    logic                 r_gain_ready;
    logic                 r_ack;
    logic                 r_nack;
    logic                 w_ack_nxt;
    logic                 w_nack_nxt;
    logic [FLASH_W-1:0]   r_flash_cnt;
    logic                 w_frame_tick;
    logic                 w_apply;
    logic                 w_spend;
    logic [NUM_CELLS-1:0] w_unit_done;
    logic [3:0]           w_unit_prog;
    logic                 w_unit_cell;
    logic                 w_cell_done;

`ifdef ENERGY_REGEN_EN
    localparam int                 REGEN_W    = cnt_width(REGEN_FRAMES);
    localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(REGEN_FRAMES - 1);
    localparam logic [REGEN_W-1:0] REGEN_ONE  = REGEN_W'(1);

    logic [REGEN_W-1:0] r_regen_cnt;
    logic               r_regen_pending;
    logic               w_regen_clr;
`endif

    frame_tick_detect u_frame_tick (
        .CLK       (CLK),
        .RESET_H   (RESET_H),
        .FRAME_CLK (FRAME_CLK),
        .FrameTick (w_frame_tick)
    );

    // Result of applying one energy unit to the current bar state.
    always_comb begin
        w_unit_done = r_done;
        w_unit_prog = r_prog;
        w_unit_cell = 1'b0;
        if (&r_done) begin
            w_unit_prog = 4'd0;
        end else if (r_prog >= PROG_MAX) begin
            w_unit_prog = 4'd0;
            w_unit_done = {r_done[NUM_CELLS-2:0], 1'b1};
            w_unit_cell = 1'b1;
        end else begin
            w_unit_prog = r_prog + 4'd1;
        end
    end

    // Main FSM: decides per cycle whether a unit is applied or a cell spent.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_apply       = 1'b0;
        w_spend       = 1'b0;
        w_ack_nxt     = 1'b0;
        w_nack_nxt    = 1'b0;
`ifdef ENERGY_REGEN_EN
        w_regen_clr   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // A spend request wins over a simultaneous gain offer.
                if (SpendReq) begin
                    w_state_nxt = SPEND;
                end else if (GainValid) begin
                    if (r_gain_ready) begin
                        w_pending_nxt = GainAmt;
                        w_state_nxt   = ADD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
`ifdef ENERGY_REGEN_EN
                    if (r_regen_pending) begin
                        w_apply     = 1'b1;
                        w_regen_clr = 1'b1;
                    end else begin
                        w_apply = 1'b0;
                    end
`else
                    w_apply = 1'b0;
`endif
                end
            end
            ADD: begin
                if (r_pending != 4'd0) begin
                    w_apply       = 1'b1;
                    w_pending_nxt = r_pending - 4'd1;
                end else begin
                    w_pending_nxt = 4'd0;
                end
                if (r_pending <= 4'd1) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ADD;
                end
            end
            SPEND: begin
                if (r_done[0]) begin
                    w_spend   = 1'b1;
                    w_ack_nxt = 1'b1;
                end else begin
                    w_nack_nxt = 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = 4'd0;
            end
        endcase
    end

    // Next bar contents; spending removes the top filled cell and keeps progress.
    always_comb begin
        w_done_nxt  = r_done;
        w_prog_nxt  = r_prog;
        w_cell_done = 1'b0;
        if (w_apply) begin
            w_done_nxt  = w_unit_done;
            w_prog_nxt  = w_unit_prog;
            w_cell_done = w_unit_cell;
        end else if (w_spend) begin
            w_done_nxt = r_done >> 1;
        end else begin
            w_done_nxt = r_done;
        end
    end

    // FSM, bar state and handshake output registers.
    always_ff @(posedge CLK) begin
        if (RESET_H) begin
            r_state      <= IDLE;
            r_pending    <= 4'd0;
            r_done       <= '0;
            r_prog       <= 4'd0;
            r_full       <= 1'b0;
            r_gain_ready <= 1'b0;
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_done       <= w_done_nxt;
            r_prog       <= w_prog_nxt;
            r_full       <= &w_done_nxt;
            r_gain_ready <= (w_state_nxt == IDLE);
            r_ack        <= w_ack_nxt;
            r_nack       <= w_nack_nxt;
        end
    end

    // Flash counter: reloads on every cell completion, counts frame ticks down to 0.
    always_ff @(posedge CLK) begin
        if (RESET_H) begin
            r_flash_cnt <= '0;
        end else if (w_cell_done) begin
            r_flash_cnt <= FLASH_LOAD;
        end else if (w_frame_tick && (r_flash_cnt != '0)) begin
            r_flash_cnt <= r_flash_cnt - FLASH_ONE;
        end else begin
            r_flash_cnt <= r_flash_cnt;
        end
    end

`ifdef ENERGY_REGEN_EN
    // Regen timer: one outstanding regen unit at most; a new event outranks a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RESET_H) begin
            r_regen_cnt     <= '0;
            r_regen_pending <= 1'b0;
        end else if (w_frame_tick && (r_regen_cnt == REGEN_LAST)) begin
            r_regen_cnt     <= '0;
            r_regen_pending <= 1'b1;
        end else begin
            if (w_frame_tick) begin
                r_regen_cnt <= r_regen_cnt + REGEN_ONE;
            end else begin
                r_regen_cnt <= r_regen_cnt;
            end
            if (w_regen_clr) begin
                r_regen_pending <= 1'b0;
            end else begin
                r_regen_pending <= r_regen_pending;
            end
        end
    end
`endif

    assign GainReady      = r_gain_ready;
    assign SpendAck       = r_ack;
    assign SpendNack      = r_nack;
    assign EnergyDone     = r_done;
    assign EnergyProgress = r_prog;
    assign EnergyFull     = r_full;
    assign CellFlash      = (r_flash_cnt != '0);

endmodule

// File: tb/tb_energy_controller.sv
// Self-checking bench for energy_controller: directed scenarios plus random
// gain/spend traffic against a cell-count/progress reference model.
module tb_energy_controller;

    logic       CLK = 1'b0;
    logic       RESET_H;
    logic       FRAME_CLK;
    logic       GainValid;
    logic [3:0] GainAmt;
    logic       GainReady;
    logic       SpendReq;
    logic       SpendAck;
    logic       SpendNack;
    logic [4:0] EnergyDone;
    logic [3:0] EnergyProgress;
    logic       EnergyFull;
    logic       CellFlash;

    int checks = 0;
    int errors = 0;
    int m_cells;
    int m_prog;
    int m_flash;

    always #5 CLK = ~CLK;

    energy_controller dut (
        .CLK            (CLK),
        .RESET_H        (RESET_H),
        .FRAME_CLK      (FRAME_CLK),
        .GainValid      (GainValid),
        .GainAmt        (GainAmt),
        .GainReady      (GainReady),
        .SpendReq       (SpendReq),
        .SpendAck       (SpendAck),
        .SpendNack      (SpendNack),
        .EnergyDone     (EnergyDone),
        .EnergyProgress (EnergyProgress),
        .EnergyFull     (EnergyFull),
        .CellFlash      (CellFlash)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] thermo(input int n);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        return v[4:0];
    endfunction

    // One energy unit as seen by the player: 16 units fill a cell, 5 cells max.
    function automatic void model_unit();
        if (m_cells == 5) begin
            m_prog = 0;
        end else if (m_prog == 15) begin
            m_prog  = 0;
            m_cells = m_cells + 1;
            m_flash = 8;
        end else begin
            m_prog = m_prog + 1;
        end
    endfunction

    task automatic check_state(input string tag);
        check_val({tag, "_done"}, 32'(EnergyDone), 32'(thermo(m_cells)));
        check_val({tag, "_prog"}, 32'(EnergyProgress), 32'(m_prog));
        check_val({tag, "_full"}, 32'(EnergyFull), 32'(m_cells == 5));
    endtask

    task automatic do_reset();
        RESET_H   = 1'b1;
        GainValid = 1'b0;
        SpendReq  = 1'b0;
        FRAME_CLK = 1'b0;
        GainAmt   = 4'd0;
        repeat (2) @(negedge CLK);
        check_val("rst_outs", {22'd0, GainReady, SpendAck, SpendNack, EnergyDone, EnergyProgress, EnergyFull, CellFlash}, 32'd0);
        RESET_H = 1'b0;
        m_cells = 0;
        m_prog  = 0;
        m_flash = 0;
        @(negedge CLK);
        check_val("rst_ready", 32'(GainReady), 32'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!GainReady && n < 40) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic do_gain(input int amt);
        int n;
        wait_ready(n);
        GainValid = 1'b1;
        GainAmt   = 4'(amt);
        @(negedge CLK);
        GainValid = 1'b0;
        GainAmt   = 4'($urandom_range(0, 15));
        wait_ready(n);
        check_val("gain_ready", 32'(GainReady), 32'd1);
        check_val("gain_latency", 32'(n), 32'((amt > 1) ? amt : 1));
        for (int i = 0; i < amt; i++) model_unit();
        check_state("gain");
    endtask

    task automatic do_spend();
        int n;
        logic exp_ack;
        exp_ack  = (m_cells > 0);
        SpendReq = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(SpendAck || SpendNack) && n < 10);
        SpendReq = 1'b0;
        check_val("spend_latency", 32'(n), 32'd2);
        check_val("spend_acknack", {30'd0, SpendAck, SpendNack}, exp_ack ? 32'd2 : 32'd1);
        if (exp_ack) m_cells = m_cells - 1;
        check_state("spend");
        @(negedge CLK);
        check_val("spend_pulse", {30'd0, SpendAck, SpendNack}, 32'd0);
    endtask

    task automatic frame_tick();
        FRAME_CLK = 1'b1;
        repeat (2) @(negedge CLK);
        FRAME_CLK = 1'b0;
        repeat (2) @(negedge CLK);
        if (m_flash > 0) m_flash = m_flash - 1;
    endtask

    initial begin
        int n;
        int exp_prog;

        // Basic gain with latency.
        do_reset();
        do_gain(5);

        // Carry into a cell and flash for exactly 8 frame ticks.
        do_reset();
        do_gain(14);
        do_gain(3);
        check_val("flash_start", 32'(CellFlash), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            frame_tick();
            check_val("flash_tick", 32'(CellFlash), 32'(m_flash > 0));
        end

        // Spend ack keeps progress; spend on empty bar nacks.
        do_reset();
        do_gain(15);
        do_gain(15);
        do_gain(6);
        do_spend();
        do_spend();
        do_spend();

        // Fill to full, overflow discarded, then drain.
        do_reset();
        repeat (6) do_gain(15);
        do_gain(5);
        repeat (6) do_spend();

        // Spend beats a simultaneous gain; the gain lands afterwards.
        do_reset();
        do_gain(15);
        do_gain(1);
        SpendReq  = 1'b1;
        GainValid = 1'b1;
        GainAmt   = 4'd3;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(SpendAck || SpendNack) && n < 10);
        SpendReq = 1'b0;
        check_val("prio_ack", 32'(SpendAck), 32'd1);
        m_cells = m_cells - 1;
        check_state("prio_spend");
        @(negedge CLK);
        GainValid = 1'b0;
        check_val("prio_gain_taken", 32'(GainReady), 32'd0);
        wait_ready(n);
        for (int i = 0; i < 3; i++) model_unit();
        check_state("prio_gain");

        // Reset in the middle of an ADD sequence.
        GainValid = 1'b1;
        GainAmt   = 4'd15;
        @(negedge CLK);
        GainValid = 1'b0;
        repeat (3) @(negedge CLK);
        do_reset();
        check_state("mid_add_rst");

        // Idle frame ticks: regen only when compiled in.
        do_reset();
        do_gain(2);
        for (int i = 1; i <= 60; i++) begin
            frame_tick();
            if (i == 30 || i == 60) begin
`ifdef ENERGY_REGEN_EN
                exp_prog = 2 + i / 30;
`else
                exp_prog = 2;
`endif
                check_val("regen_prog", 32'(EnergyProgress), 32'(exp_prog));
            end
        end

        // Random gain/spend traffic.
        do_reset();
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) < 7) begin
                do_gain(int'($urandom_range(0, 15)));
            end else begin
                do_spend();
            end
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
